// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: register index, hazard FSM encoding, pcsrc selects
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef logic [1:0] hazard_state_t;
  localparam hazard_state_t IDLE     = 2'd0;
  localparam hazard_state_t MEM_WAIT = 2'd1;
  localparam hazard_state_t FLUSH    = 2'd2;

  localparam logic [1:0] PC_NEXT = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_J    = 2'd2;
  localparam logic [1:0] PC_JR   = 2'd3;

  // Flush-length counter; FLUSH_CYCLES is limited to 1..7.
  typedef logic [2:0] flush_cnt_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// rtl/hazard_perf_counter.sv - saturating stall-cycle counter
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush controller; HAZARD_PERF_EN adds a stall-cycle counter
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_dREN,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic [1:0]       pcsrc,
  output logic             pc_enable,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic [CNT_W-1:0] stall_count
);

  localparam flush_cnt_t FLUSH_RELOAD = flush_cnt_t'(FLUSH_CYCLES - 1);
  // A deferred redirect gets no flush on the dhit cycle, so FLUSH carries all cycles.
  localparam flush_cnt_t FLUSH_FULL   = flush_cnt_t'(FLUSH_CYCLES);

  hazard_state_t state_q, state_d;
  flush_cnt_t    cnt_q, cnt_d, cnt_next;
  logic          pend_q, pend_d;

  logic mem_stall, redirect, load_use;
  logic pc_en_c, ifid_en_c, exmem_en_c, ifid_fl_c, idex_fl_c;

  assign mem_stall = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign redirect  = (pcsrc != PC_NEXT);
  assign load_use  = idex_dREN && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    cnt_next   = cnt_q;
    pc_en_c    = 1'b1;
    ifid_en_c  = 1'b1;
    exmem_en_c = 1'b1;
    ifid_fl_c  = 1'b0;
    idex_fl_c  = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        if (redirect) pend_d = 1'b1;
        if (!dhit) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          exmem_en_c = 1'b0;
        end else if (pend_q || redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_FULL;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
          if (load_use || !ihit) begin
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
            idex_fl_c = 1'b1;
          end
        end
      end

      FLUSH: begin
        if (mem_stall) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          exmem_en_c = 1'b0;
          state_d    = MEM_WAIT;
          pend_d     = 1'b1;
        end else begin
          ifid_fl_c = 1'b1;
          idex_fl_c = redirect;
          cnt_next  = redirect ? FLUSH_RELOAD : flush_cnt_t'(cnt_q - 3'd1);
          cnt_d     = cnt_next;
          if (cnt_next == '0) state_d = IDLE;
        end
      end

      IDLE: begin
        if (mem_stall) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          exmem_en_c = 1'b0;
          state_d    = MEM_WAIT;
        end else if (redirect) begin
          ifid_fl_c = 1'b1;
          idex_fl_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (load_use || !ihit) begin
          pc_en_c   = 1'b0;
          ifid_en_c = 1'b0;
          idex_fl_c = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Reset must silence every enable immediately, not at the next edge.
  assign pc_enable  = nRST & pc_en_c;
  assign ifid_en    = nRST & ifid_en_c;
  assign exmem_en   = nRST & exmem_en_c;
  assign ifid_flush = nRST & ifid_fl_c;
  assign idex_flush = nRST & idex_fl_c;

`ifdef HAZARD_PERF_EN
  hazard_perf_counter #(
    .W(CNT_W)
  ) u_perf (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .inc_i  (~pc_en_c),
    .count_o(stall_count)
  );
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES 3 and 2)
module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] PERF5 = 32'd5;
`else
  localparam logic [CNT_W-1:0] PERF5 = 32'd0;
`endif

  // {pc_enable, ifid_en, exmem_en, ifid_flush, idex_flush}
  localparam logic [4:0] NORM  = 5'b11100;
  localparam logic [4:0] STALL = 5'b00101;
  localparam logic [4:0] MEMS  = 5'b00000;
  localparam logic [4:0] ZERO  = 5'b00000;
  localparam logic [4:0] RDIR  = 5'b11111;
  localparam logic [4:0] FLST  = 5'b11110;
  localparam logic [4:0] FLRL  = 5'b11111;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit, idex_dREN, exmem_dREN, exmem_dWEN;
  regbits_t ifid_rs, ifid_rt, idex_rt;
  logic [1:0] pcsrc;

  logic pe3, ie3, ee3, if3, xf3, pe2, ie2, ee2, if2, xf2;
  logic [CNT_W-1:0] sc3, sc2;
  logic [4:0] out3, out2;
  assign out3 = {pe3, ie3, ee3, if3, xf3};
  assign out2 = {pe2, ie2, ee2, if2, xf2};

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(3), .CNT_W(CNT_W)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt), .idex_dREN(idex_dREN),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .pcsrc(pcsrc),
    .pc_enable(pe3), .ifid_en(ie3), .ifid_flush(if3), .idex_flush(xf3),
    .exmem_en(ee3), .stall_count(sc3)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt), .idex_dREN(idex_dREN),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .pcsrc(pcsrc),
    .pc_enable(pe2), .ifid_en(ie2), .ifid_flush(if2), .idex_flush(xf2),
    .exmem_en(ee2), .stall_count(sc2)
  );

  typedef struct {
    string            tag;
    logic [4:0]       e3;
    logic [4:0]       e2;
    bit               chk;
    logic [CNT_W-1:0] ecnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic idle_in();
    nRST = 1'b1; ihit = 1'b1; dhit = 1'b0;
    ifid_rs = '0; ifid_rt = '0; idex_rt = '0; idex_dREN = 1'b0;
    exmem_dREN = 1'b0; exmem_dWEN = 1'b0; pcsrc = PC_NEXT;
  endtask

  task automatic step_c(input string tag, input logic [4:0] e3, input logic [4:0] e2,
                        input bit chk, input logic [CNT_W-1:0] ecnt);
    exp_t t;
    t.tag = tag; t.e3 = e3; t.e2 = e2; t.chk = chk; t.ecnt = ecnt;
    exp_q.push_back(t);
    @(posedge CLK); #1;
  endtask

  task automatic step(input string tag, input logic [4:0] e3, input logic [4:0] e2);
    step_c(tag, e3, e2, 1'b0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (out3 !== e.e3) begin
          n_bad++;
          $display("FAIL %s fc3 outputs got %b expected %b", e.tag, out3, e.e3);
        end
        if (out2 !== e.e2) begin
          n_bad++;
          $display("FAIL %s fc2 outputs got %b expected %b", e.tag, out2, e.e2);
        end
        if (e.chk && (sc3 !== e.ecnt || sc2 !== e.ecnt)) begin
          n_bad++;
          $display("FAIL %s stall_count got %0d/%0d expected %0d", e.tag, sc3, sc2, e.ecnt);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    idle_in();
    nRST = 1'b0;
    @(posedge CLK); #1;
    step_c("rst_hold", ZERO, ZERO, 1'b1, '0);
    nRST = 1'b1;
    step_c("rst_rel", NORM, NORM, 1'b1, '0);

    // load-use through rs, through rt, and the r0 exemption
    idex_dREN = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    step("lu_rs", STALL, STALL);
    ifid_rs = 5'd3; ifid_rt = 5'd8;
    step("lu_rt", STALL, STALL);
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    step("lu_r0", NORM, NORM);
    idle_in(); ihit = 1'b0;
    step("fetch", STALL, STALL);
    idle_in();
    step("norm", NORM, NORM);

    // memory wait: three dhit-low cycles, then release
    exmem_dREN = 1'b1;
    step("mw1", MEMS, MEMS);
    step("mw2", MEMS, MEMS);
    step("mw3", MEMS, MEMS);
    dhit = 1'b1;
    step("mw_hit", NORM, NORM);
    idle_in(); exmem_dWEN = 1'b1;
    step("mw_wr", MEMS, MEMS);
    dhit = 1'b1;
    step("mw_wr_hit", NORM, NORM);
    idle_in();
    step("mw_after", NORM, NORM);

    // redirect deferred during MEM_WAIT
    exmem_dREN = 1'b1;
    step("dr_stall", MEMS, MEMS);
    pcsrc = PC_J;
    step("dr_pend", MEMS, MEMS);
    pcsrc = PC_NEXT;
    step("dr_wait", MEMS, MEMS);
    dhit = 1'b1;
    step("dr_hit", NORM, NORM);
    idle_in();
    step("dr_f1", FLST, FLST);
    step("dr_f2", FLST, FLST);
    step("dr_f3", FLST, NORM);
    step("dr_end", NORM, NORM);

    // back-to-back redirects reload the flush counter
    pcsrc = PC_BR;
    step("rl_0", RDIR, RDIR);
    step("rl_1", FLRL, FLRL);
    pcsrc = PC_NEXT;
    step("rl_2", FLST, FLST);
    step("rl_3", FLST, NORM);
    step("rl_end", NORM, NORM);

    // redirect beats a coincident load-use
    pcsrc = PC_JR; idex_dREN = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    step("pr_0", RDIR, RDIR);
    pcsrc = PC_NEXT;
    step("pr_1", FLST, FLST);
    idle_in();
    step("pr_2", FLST, NORM);
    step("pr_end", NORM, NORM);

    // reset asserted mid-FLUSH
    pcsrc = PC_BR;
    step("rf_0", RDIR, RDIR);
    pcsrc = PC_NEXT; nRST = 1'b0;
    step("rf_rst", ZERO, ZERO);
    step("rf_hold", ZERO, ZERO);
    nRST = 1'b1;
    step("rf_rel", NORM, NORM);

    // reset asserted mid-MEM_WAIT with a pending redirect
    exmem_dREN = 1'b1;
    step("rm_0", MEMS, MEMS);
    pcsrc = PC_J;
    step("rm_pend", MEMS, MEMS);
    idle_in(); nRST = 1'b0;
    step_c("rm_rst", ZERO, ZERO, 1'b1, '0);
    nRST = 1'b1;
    step("rm_rel", NORM, NORM);
    step("rm_idle", NORM, NORM);

    // five stall cycles for the performance counter
    ihit = 1'b0;
    for (int i = 0; i < 5; i++) step("perf_stall", STALL, STALL);
    idle_in();
    step_c("perf_cnt", NORM, NORM, 1'b1, PERF5);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge CLK); #1;
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
